ntt_bf_feeder: RTL and testbench

Issue-side sequencer for one NTT/INTT pass of the 2x2 butterfly network. On `start` it reads 64 four-coefficient words from coefficient memory and fetches the matching four twiddle factors from the twiddle ROM. It drives `bf_uvw_o` with `bf_enable_o` into the butterfly network, then counts the network's ready pulses and reports `done_o` once all 64 results have emerged. It sits between the memory/ROM read ports and the butterfly network inside the NTT top controller.

---
 rtl/ntt_defines_pkg.sv | 47 ++++
 rtl/ntt_twiddle_addr_gen.sv | 22 ++
 rtl/ntt_bf_feeder.sv | 172 +++++++++++++++++
 tb/tb_ntt_bf_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_defines_pkg.sv
// Shared NTT types plus the constants used by the butterfly feeder.
// Consumed by ntt_twiddle_addr_gen and ntt_bf_feeder.
package ntt_defines_pkg;

   localparam int BF_REG_SIZE = 23;

   typedef enum logic [1:0] {
      CT  = 2'd0,
      GS  = 2'd1,
      PWO = 2'd2,
      PWA = 2'd3
   } mode_t;

   typedef struct packed {
      logic [BF_REG_SIZE-1:0] u00;
      logic [BF_REG_SIZE-1:0] u01;
      logic [BF_REG_SIZE-1:0] v00;
      logic [BF_REG_SIZE-1:0] v01;
      logic [BF_REG_SIZE-1:0] w00;
      logic [BF_REG_SIZE-1:0] w01;
      logic [BF_REG_SIZE-1:0] w10;
      logic [BF_REG_SIZE-1:0] w11;
   } bf_uvwi_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feeder_state_e;

   localparam int NTT_FEEDER_NUM_ISSUE = 64;

   // Indexed by effective pass: element 0 is the lowest slice.
   localparam logic [3:0][6:0] TW_BASE  = {7'd21, 7'd5, 7'd1, 7'd0};
   localparam logic [3:0][2:0] TW_SHIFT = {3'd0, 3'd2, 3'd4, 3'd6};

   // GS walks the twiddle table from the opposite end to CT.
   function automatic logic [1:0] calc_eff_pass(input mode_t mode, input logic [1:0] pass_idx);
      if (mode == GS) begin
         return 2'd3 - pass_idx;
      end else begin
         return pass_idx;
      end
   endfunction

endpackage

// File: rtl/ntt_twiddle_addr_gen.sv
// Combinational twiddle ROM address for the current issue slot.
module ntt_twiddle_addr_gen
   import ntt_defines_pkg::*;
#(
   parameter int TW_ADDR_WIDTH = 7
) (
   input  mode_t                    mode,
   input  logic [1:0]               pass_idx,
   input  logic [6:0]               issue_cnt,
   output logic [TW_ADDR_WIDTH-1:0] tw_addr
);

   logic [1:0] eff_pass;
   logic [6:0] offset;
   logic [6:0] sum;

   assign eff_pass = calc_eff_pass(mode, pass_idx);
   assign offset   = issue_cnt >> TW_SHIFT[eff_pass];
   assign sum      = TW_BASE[eff_pass] + offset;
   assign tw_addr  = TW_ADDR_WIDTH'(sum);

endmodule

// File: rtl/ntt_bf_feeder.sv
// Issue-side sequencer for one NTT/INTT butterfly pass.
// Optional stall-cycle counter enabled by defining NTT_FEEDER_STALL_CNT_EN.
module ntt_bf_feeder
   import ntt_defines_pkg::*;
#(
   parameter int REG_SIZE      = 23,
   parameter int ADDR_WIDTH    = 15,
   parameter int TW_ADDR_WIDTH = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      zeroize,
   input  logic                      start,
   input  mode_t                     mode_i,
   input  logic [1:0]                pass_idx_i,
   input  logic [ADDR_WIDTH-1:0]     src_base_addr_i,
   input  logic                      stall_i,
   output logic                      mem_rd_en_o,
   output logic [ADDR_WIDTH-1:0]     mem_rd_addr_o,
   input  logic [4*REG_SIZE-1:0]     mem_rd_data_i,
   output logic                      tw_rd_en_o,
   output logic [TW_ADDR_WIDTH-1:0]  tw_addr_o,
   input  logic [4*REG_SIZE-1:0]     tw_data_i,
   output logic                      bf_enable_o,
   output bf_uvwi_t                  bf_uvw_o,
   input  logic                      bf_ready_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [15:0]               stall_cycles_o
);

   feeder_state_e            state;
   mode_t                    mode;
   logic [1:0]               pass_idx;
   logic [ADDR_WIDTH-1:0]    base_addr;
   logic [6:0]               issue_cnt;
   logic [6:0]               result_cnt;
   logic [TW_ADDR_WIDTH-1:0] tw_addr_next;
   logic                     last_issue;
   logic                     last_result;

   assign last_issue  = (issue_cnt == 7'(NTT_FEEDER_NUM_ISSUE - 1));
   // The 64th result may be counted on this very edge.
   assign last_result = (result_cnt == 7'(NTT_FEEDER_NUM_ISSUE)) ||
                        (bf_ready_i && (result_cnt == 7'(NTT_FEEDER_NUM_ISSUE - 1)));

   ntt_twiddle_addr_gen #(
      .TW_ADDR_WIDTH (TW_ADDR_WIDTH)
   ) u_tw_addr_gen (
      .mode      (mode),
      .pass_idx  (pass_idx),
      .issue_cnt (issue_cnt),
      .tw_addr   (tw_addr_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         mode          <= CT;
         pass_idx      <= 2'd0;
         base_addr     <= '0;
         issue_cnt     <= 7'd0;
         result_cnt    <= 7'd0;
         mem_rd_en_o   <= 1'b0;
         mem_rd_addr_o <= '0;
         tw_rd_en_o    <= 1'b0;
         tw_addr_o     <= '0;
         bf_enable_o   <= 1'b0;
         bf_uvw_o      <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else if (zeroize) begin
         state         <= IDLE;
         mode          <= CT;
         pass_idx      <= 2'd0;
         base_addr     <= '0;
         issue_cnt     <= 7'd0;
         result_cnt    <= 7'd0;
         mem_rd_en_o   <= 1'b0;
         mem_rd_addr_o <= '0;
         tw_rd_en_o    <= 1'b0;
         tw_addr_o     <= '0;
         bf_enable_o   <= 1'b0;
         bf_uvw_o      <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         mem_rd_en_o <= 1'b0;
         tw_rd_en_o  <= 1'b0;
         done_o      <= 1'b0;
         bf_enable_o <= mem_rd_en_o;
         busy_o      <= (state == ISSUE) || (state == DRAIN);

         // Read data belongs to the strobe of the previous cycle.
         if (mem_rd_en_o) begin
            bf_uvw_o.u00 <= mem_rd_data_i[0*REG_SIZE +: REG_SIZE];
            bf_uvw_o.v00 <= mem_rd_data_i[1*REG_SIZE +: REG_SIZE];
            bf_uvw_o.u01 <= mem_rd_data_i[2*REG_SIZE +: REG_SIZE];
            bf_uvw_o.v01 <= mem_rd_data_i[3*REG_SIZE +: REG_SIZE];
            bf_uvw_o.w00 <= tw_data_i[0*REG_SIZE +: REG_SIZE];
            bf_uvw_o.w01 <= tw_data_i[1*REG_SIZE +: REG_SIZE];
            bf_uvw_o.w10 <= tw_data_i[2*REG_SIZE +: REG_SIZE];
            bf_uvw_o.w11 <= tw_data_i[3*REG_SIZE +: REG_SIZE];
         end

         case (state)
            IDLE: begin
               if (start) begin
                  mode       <= mode_i;
                  pass_idx   <= pass_idx_i;
                  base_addr  <= src_base_addr_i;
                  issue_cnt  <= 7'd0;
                  result_cnt <= 7'd0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (!stall_i) begin
                  mem_rd_en_o   <= 1'b1;
                  tw_rd_en_o    <= 1'b1;
                  mem_rd_addr_o <= base_addr + ADDR_WIDTH'(issue_cnt);
                  tw_addr_o     <= tw_addr_next;
                  issue_cnt     <= issue_cnt + 7'd1;
                  if (last_issue) begin
                     state <= DRAIN;
                  end
               end
               if (bf_ready_i) begin
                  result_cnt <= result_cnt + 7'd1;
               end
            end
            DRAIN: begin
               if (bf_ready_i) begin
                  result_cnt <= result_cnt + 7'd1;
               end
               if (last_result) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef NTT_FEEDER_STALL_CNT_EN
   logic [15:0] stall_cnt;

   // Saturating count of stalled issue cycles; value survives past done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 16'd0;
      end else if (zeroize) begin
         stall_cnt <= 16'd0;
      end else if ((state == IDLE) && start) begin
         stall_cnt <= 16'd0;
      end else if ((state == ISSUE) && stall_i && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign stall_cycles_o = stall_cnt;
`else
   assign stall_cycles_o = 16'd0;
`endif

endmodule

// File: tb/tb_ntt_bf_feeder.sv
// Directed, table-driven bench for ntt_bf_feeder with a memory/ROM echo
// model and a 10-cycle butterfly ready echo.
module tb_ntt_bf_feeder;
   import ntt_defines_pkg::*;

   localparam int RS  = 23;
   localparam int AW  = 15;
   localparam int TWW = 7;

   logic            clk = 1'b0;
   logic            reset, zeroize, start, stall_i, bf_ready_i;
   mode_t           mode_i;
   logic [1:0]      pass_idx_i;
   logic [AW-1:0]   src_base_addr_i;
   logic            mem_rd_en_o, tw_rd_en_o, bf_enable_o, busy_o, done_o;
   logic [AW-1:0]   mem_rd_addr_o;
   logic [TWW-1:0]  tw_addr_o;
   logic [4*RS-1:0] mem_rd_data_i, tw_data_i;
   bf_uvwi_t        bf_uvw_o;
   logic [15:0]     stall_cycles_o;

   ntt_bf_feeder #(.REG_SIZE(RS), .ADDR_WIDTH(AW), .TW_ADDR_WIDTH(TWW)) dut (
      .clk(clk), .reset(reset), .zeroize(zeroize), .start(start),
      .mode_i(mode_i), .pass_idx_i(pass_idx_i), .src_base_addr_i(src_base_addr_i),
      .stall_i(stall_i), .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
      .mem_rd_data_i(mem_rd_data_i), .tw_rd_en_o(tw_rd_en_o), .tw_addr_o(tw_addr_o),
      .tw_data_i(tw_data_i), .bf_enable_o(bf_enable_o), .bf_uvw_o(bf_uvw_o),
      .bf_ready_i(bf_ready_i), .busy_o(busy_o), .done_o(done_o),
      .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory/ROM models: data is a fixed function of the address presented.
   logic [RS-1:0] a23, t23;
   assign a23 = RS'(mem_rd_addr_o);
   assign t23 = RS'(tw_addr_o);
   assign mem_rd_data_i = {a23 + 23'd3000, a23 + 23'd2000, a23 + 23'd1000, a23};
   assign tw_data_i     = {t23 + 23'd700, t23 + 23'd500, t23 + 23'd300, t23 + 23'd100};

   // Butterfly network model: ready echoes each enable 10 cycles later.
   logic [9:0] sr;
   logic       extra_ready;
   always @(posedge clk or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= {sr[8:0], bf_enable_o};
   end
   assign bf_ready_i = sr[9] | extra_ready;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      mode_t         mode;
      logic [1:0]    pass;
      logic [AW-1:0] base;
      int            stall_at;
      int            stall_len;
      int            extra_start_at;
      bit            pre_ready;
      int            exp_first_rel;
      int            exp_rel10;
      logic [AW-1:0] exp_last_addr;
      logic [TWW-1:0] exp_tw0;
      logic [TWW-1:0] exp_tw10;
      logic [TWW-1:0] exp_tw63;
      int            exp_done_rel;
      int            exp_stall;
   } vec_t;

   logic [AW-1:0]  addr_q[$];
   logic [TWW-1:0] tw_q[$];
   int             rel_q[$];
   int n_en, n_done, done_rel, n_busy, data_err;

   task automatic run_pass(input vec_t v);
      int rel, t0;
      bit pend;
      logic [AW-1:0]  pa;
      logic [TWW-1:0] pt;
      addr_q.delete(); tw_q.delete(); rel_q.delete();
      n_en = 0; n_done = 0; done_rel = -1; n_busy = 0; data_err = 0;
      pend = 1'b0; pa = '0; pt = '0;
      if (v.pre_ready) begin
         extra_ready = 1'b1;
         repeat (3) @(negedge clk);
         extra_ready = 1'b0;
      end
      @(negedge clk);
      mode_i = v.mode; pass_idx_i = v.pass; src_base_addr_i = v.base; start = 1'b1;
      @(negedge clk);
      start = 1'b0; t0 = cyc;
      // Scramble inputs after the start edge; the block must use latched copies.
      mode_i = GS; pass_idx_i = ~v.pass; src_base_addr_i = ~v.base;
      for (int k = 0; k < 400; k++) begin
         rel = cyc - t0;
         if (tw_rd_en_o !== mem_rd_en_o) data_err++;
         if (bf_enable_o !== pend) data_err++;
         else if (pend && ((bf_uvw_o.u00 !== RS'(pa)) || (bf_uvw_o.v00 !== RS'(pa) + 23'd1000) ||
                           (bf_uvw_o.u01 !== RS'(pa) + 23'd2000) || (bf_uvw_o.v01 !== RS'(pa) + 23'd3000) ||
                           (bf_uvw_o.w00 !== RS'(pt) + 23'd100) || (bf_uvw_o.w01 !== RS'(pt) + 23'd300) ||
                           (bf_uvw_o.w10 !== RS'(pt) + 23'd500) || (bf_uvw_o.w11 !== RS'(pt) + 23'd700)))
            data_err++;
         pend = mem_rd_en_o;
         if (mem_rd_en_o) begin
            pa = mem_rd_addr_o; pt = tw_addr_o;
            addr_q.push_back(mem_rd_addr_o); tw_q.push_back(tw_addr_o); rel_q.push_back(rel);
         end
         if (bf_enable_o) n_en++;
         if (busy_o) n_busy++;
         if (done_o) begin n_done++; done_rel = rel; end
         if (done_rel >= 0 && rel >= done_rel + 3) break;
         if (v.stall_at >= 0 && rel == v.stall_at) stall_i = 1'b1;
         if (v.stall_at >= 0 && rel == v.stall_at + v.stall_len) stall_i = 1'b0;
         start = (rel == v.extra_start_at);
         @(negedge clk);
      end
      stall_i = 1'b0; start = 1'b0;
   endtask

   task automatic check_pass(input int idx, input vec_t v);
      int aerr;
      int exp_st;
      aerr = 0;
      for (int i = 0; i < addr_q.size(); i++)
         if (addr_q[i] !== AW'(v.base + AW'(i))) aerr++;
      chk($sformatf("v%0d_n_strobe", idx), addr_q.size(), 64);
      chk($sformatf("v%0d_addr_seq", idx), aerr, 0);
      chk($sformatf("v%0d_first_rel", idx), (rel_q.size() > 0) ? rel_q[0] : -1, v.exp_first_rel);
      chk($sformatf("v%0d_rel10", idx), (rel_q.size() > 10) ? rel_q[10] : -1, v.exp_rel10);
      chk($sformatf("v%0d_last_addr", idx), (addr_q.size() > 0) ? 32'(addr_q[$]) : 32'hDEAD, 32'(v.exp_last_addr));
      chk($sformatf("v%0d_tw0", idx), (tw_q.size() > 0) ? 32'(tw_q[0]) : 32'hDEAD, 32'(v.exp_tw0));
      chk($sformatf("v%0d_tw10", idx), (tw_q.size() > 10) ? 32'(tw_q[10]) : 32'hDEAD, 32'(v.exp_tw10));
      chk($sformatf("v%0d_tw63", idx), (tw_q.size() > 63) ? 32'(tw_q[63]) : 32'hDEAD, 32'(v.exp_tw63));
      chk($sformatf("v%0d_data", idx), data_err, 0);
      chk($sformatf("v%0d_n_enable", idx), n_en, 64);
      chk($sformatf("v%0d_n_done", idx), n_done, 1);
      chk($sformatf("v%0d_done_rel", idx), done_rel, v.exp_done_rel);
      chk($sformatf("v%0d_busy_cycles", idx), n_busy, v.exp_done_rel);
`ifdef NTT_FEEDER_STALL_CNT_EN
      exp_st = v.exp_stall;
`else
      exp_st = 0;
`endif
      chk($sformatf("v%0d_stall_cycles", idx), stall_cycles_o, exp_st);
   endtask

   vec_t vecs[9];

   initial begin
      int n, seen;
      //           mode pass base     stall len xst pre first r10  last      tw0 tw10 tw63 done stall
      vecs[0] = '{CT, 2'd0, 15'h0100, -1,   0, -1, 0, 1,    11,  15'h013F, 7'd0,  7'd0,  7'd0,  76, 0};
      vecs[1] = '{CT, 2'd3, 15'h0200, -1,   0, 20, 1, 1,    11,  15'h023F, 7'd21, 7'd31, 7'd84, 76, 0};
      vecs[2] = '{GS, 2'd0, 15'h0000, -1,   0, -1, 0, 1,    11,  15'h003F, 7'd21, 7'd31, 7'd84, 76, 0};
      vecs[3] = '{GS, 2'd3, 15'h0040, -1,   0, -1, 0, 1,    11,  15'h007F, 7'd0,  7'd0,  7'd0,  76, 0};
      vecs[4] = '{CT, 2'd1, 15'h0300, -1,   0, -1, 0, 1,    11,  15'h033F, 7'd1,  7'd1,  7'd4,  76, 0};
      vecs[5] = '{GS, 2'd1, 15'h0000, -1,   0, -1, 0, 1,    11,  15'h003F, 7'd5,  7'd7,  7'd20, 76, 0};
      vecs[6] = '{CT, 2'd0, 15'h0100, 10,   5, -1, 0, 1,    16,  15'h013F, 7'd0,  7'd0,  7'd0,  81, 5};
      vecs[7] = '{CT, 2'd0, 15'h7FE0, -1,   0, -1, 0, 1,    11,  15'h001F, 7'd0,  7'd0,  7'd0,  76, 0};
      vecs[8] = '{CT, 2'd2, 15'h0050, 0,  100, -1, 0, 101,  111, 15'h008F, 7'd5,  7'd7,  7'd20, 176, 100};

      reset = 1'b1; zeroize = 1'b0; start = 1'b0; stall_i = 1'b0; extra_ready = 1'b0;
      mode_i = CT; pass_idx_i = 2'd0; src_base_addr_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {31'd0, (mem_rd_en_o | tw_rd_en_o | bf_enable_o | busy_o | done_o)}, 32'd0);
      chk("rst_addr", {mem_rd_addr_o, 10'd0, tw_addr_o}, 32'd0);
      chk("rst_uvw", {31'd0, (bf_uvw_o == '0)}, 32'd1);
      chk("rst_stall_cnt", stall_cycles_o, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_pass(vecs[i]);
         check_pass(i, vecs[i]);
         repeat (2) @(negedge clk);
      end

      // Reset in the middle of a pass, then a clean pass afterwards.
      @(negedge clk);
      mode_i = CT; pass_idx_i = 2'd0; src_base_addr_i = 15'h0100; start = 1'b1;
      @(negedge clk);
      start = 1'b0; n = 0;
      for (int k = 0; k < 100; k++) begin
         if (mem_rd_en_o) n++;
         if (n == 30) break;
         @(negedge clk);
      end
      chk("midrst_reached30", n, 30);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_outputs", {31'd0, (mem_rd_en_o | tw_rd_en_o | bf_enable_o | busy_o | done_o)}, 32'd0);
      chk("midrst_addr", {mem_rd_addr_o, 10'd0, tw_addr_o}, 32'd0);
      chk("midrst_uvw", {31'd0, (bf_uvw_o == '0)}, 32'd1);
      reset = 1'b0; seen = 0;
      repeat (30) begin
         if (done_o || busy_o || mem_rd_en_o) seen++;
         @(negedge clk);
      end
      chk("midrst_quiet", seen, 0);
      run_pass(vecs[0]);
      check_pass(9, vecs[0]);

      // zeroize together with start must win.
      @(negedge clk);
      zeroize = 1'b1; start = 1'b1;
      @(negedge clk);
      zeroize = 1'b0; start = 1'b0; seen = 0;
      repeat (5) begin
         if (mem_rd_en_o || busy_o || done_o) seen++;
         @(negedge clk);
      end
      chk("zeroize_start", seen, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
